// File: rtl/debug_pkg.sv
// Shared constants for the debug execution controller: opcodes, run states, parser states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package debug_pkg;

    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STOP  = 8'h53;
    localparam logic [7:0] CMD_STEP  = 8'h4E;
    localparam logic [7:0] CMD_COUNT = 8'h43;

    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_STEP    = 2'd2;
    localparam logic [1:0] ST_HALTED  = 2'd3;

    localparam logic [1:0] PS_IDLE  = 2'd0;
    localparam logic [1:0] PS_OP_HI = 2'd1;
    localparam logic [1:0] PS_OP_LO = 2'd2;

    typedef struct packed {
        logic run;
        logic stop;
        logic step;
        logic count;
    } cmd_dec_t;

    function automatic cmd_dec_t decode_cmd(input logic [7:0] b);
        cmd_dec_t d;
        d.run   = (b == CMD_RUN);
        d.stop  = (b == CMD_STOP);
        d.step  = (b == CMD_STEP);
        d.count = (b == CMD_COUNT);
        return d;
    endfunction

endpackage

// File: rtl/debug_exec_ctrl_if.sv
// Debug link byte streams: host command bytes in, response bytes out.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both streams; transfer when both are high at a clock edge.
interface debug_exec_ctrl_if;
    logic       cmd_valid;
    logic [7:0] cmd;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ready;

    modport master (
        output cmd_valid, cmd, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/debug_exec_ctrl_rsp_serializer.sv
// Serializes a SIZE-bit word into SIZE/8 response bytes, most significant byte first.
// Latency: first byte valid the cycle after load; one byte per accepted handshake.
// Backpressure: holds the current byte stable while rsp_ready is low; busy stays high until the last handshake.
module rsp_serializer #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [SIZE-1:0] load_word,
    output logic            busy,
    output logic            rsp_valid,
    output logic [7:0]      rsp_data,
    input  logic            rsp_ready
);
    localparam int NBYTES = SIZE / 8;
    localparam int IDX_W  = $clog2(NBYTES + 1);

    logic              busy_q, busy_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SIZE-1:0]   word_q, word_d;

    // Shift out one byte per handshake; a load is only honoured while idle.
    always_comb begin
        busy_d = busy_q;
        idx_d  = idx_q;
        word_d = word_q;
        if (busy_q) begin
            if (rsp_ready) begin
                word_d = word_q << 8;
                if (idx_q == IDX_W'(NBYTES - 1)) begin
                    busy_d = 1'b0;
                    idx_d  = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end else if (load) begin
            busy_d = 1'b1;
            idx_d  = '0;
            word_d = load_word;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            busy_q <= busy_d;
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign busy      = busy_q;
    assign rsp_valid = busy_q;
    assign rsp_data  = word_q[SIZE-1 -: 8];
endmodule

// File: rtl/debug_exec_ctrl.sv
// Host-side execution controller: decodes run/stop/step/count bytes and drives the core stall.
// Latency: a command accepted at an edge changes state at that edge; o_stall follows the next cycle.
// Backpressure: command stream is held off (cmd_ready low) while a count response is being sent.
module debug_exec_ctrl
    import debug_pkg::*;
#(
    parameter int SIZE   = 32,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    debug_exec_ctrl_if.slave  dbg,
    input  logic              i_halt,
    output logic              o_stall,
    output logic              o_step_done,
    output logic [SIZE-1:0]   o_cycle_count,
    output logic [1:0]        o_state
);
    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [1:0]        pst_q, pst_d;
    logic [7:0]        op_hi_q, op_hi_d;
    logic [SIZE-1:0]   count_q, count_d;
    logic              step_done_q, step_done_d;

    logic              busy;
    logic              cmd_acc;
    logic              stall;
    cmd_dec_t          dec;
    logic              in_idle;
    logic              do_run, do_stop, do_count, do_step;
    logic [STEP_W-1:0] step_n;

    // Stall comes only from registered state so there is no input-to-stall path.
    assign stall    = !((state_q == ST_RUN) || ((state_q == ST_STEP) && (rem_q != '0)));
    assign cmd_acc  = dbg.cmd_valid && !busy;
    assign dec      = decode_cmd(dbg.cmd);
    assign in_idle  = cmd_acc && (pst_q == PS_IDLE);
    assign do_run   = in_idle && dec.run;
    assign do_stop  = in_idle && dec.stop;
    assign do_count = in_idle && dec.count;
    assign do_step  = cmd_acc && (pst_q == PS_OP_LO);
    assign step_n   = {op_hi_q, dbg.cmd};

    // Byte parser: opcodes in IDLE, two raw operand bytes after a step opcode.
    always_comb begin
        pst_d   = pst_q;
        op_hi_d = op_hi_q;
        if (cmd_acc) begin
            case (pst_q)
                PS_IDLE:  if (dec.step) pst_d = PS_OP_HI;
                PS_OP_HI: begin
                    op_hi_d = dbg.cmd;
                    pst_d   = PS_OP_LO;
                end
                default:  pst_d = PS_IDLE;
            endcase
        end
    end

    // Execution state, step countdown and cycle counter; a halt on an unstalled edge overrides everything.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        step_done_d = 1'b0;
        count_d     = stall ? count_q : count_q + SIZE'(1);
        if (!stall && i_halt) begin
            state_d = ST_HALTED;
        end else begin
            case (state_q)
                ST_STOPPED: begin
                    if (do_run) begin
                        state_d = ST_RUN;
                    end else if (do_step) begin
                        if (step_n != '0) begin
                            state_d = ST_STEP;
                            rem_d   = step_n;
                        end else begin
                            step_done_d = 1'b1;
                        end
                    end
                end
                ST_RUN:  if (do_stop) state_d = ST_STOPPED;
                ST_STEP: begin
                    if (do_stop) begin
                        state_d = ST_STOPPED;
                    end else if (!stall) begin
                        rem_d = rem_q - STEP_W'(1);
                        if (rem_q == STEP_W'(1)) begin
                            state_d     = ST_STOPPED;
                            step_done_d = 1'b1;
                        end
                    end
                end
                default: if (do_stop) state_d = ST_STOPPED;
            endcase
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_STOPPED;
            rem_q       <= '0;
            pst_q       <= PS_IDLE;
            op_hi_q     <= '0;
            count_q     <= '0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            pst_q       <= pst_d;
            op_hi_q     <= op_hi_d;
            count_q     <= count_d;
            step_done_q <= step_done_d;
        end
    end

    // The snapshot includes this edge's increment.
    rsp_serializer #(.SIZE(SIZE)) u_rsp (
        .clk       (clk),
        .rst       (rst),
        .load      (do_count),
        .load_word (count_d),
        .busy      (busy),
        .rsp_valid (dbg.rsp_valid),
        .rsp_data  (dbg.rsp_data),
        .rsp_ready (dbg.rsp_ready)
    );

    assign dbg.cmd_ready = !busy;
    assign o_stall       = stall;
    assign o_step_done   = step_done_q;
    assign o_cycle_count = count_q;
    assign o_state       = state_q;
endmodule

// File: tb/tb_debug_exec_ctrl.sv
module tb_debug_exec_ctrl;
    import debug_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_halt = 1'b0;
    logic        o_stall, o_step_done;
    logic [31:0] o_cycle_count;
    logic [1:0]  o_state;

    debug_exec_ctrl_if bus();

    debug_exec_ctrl #(.SIZE(32), .STEP_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .dbg           (bus),
        .i_halt        (i_halt),
        .o_stall       (o_stall),
        .o_step_done   (o_step_done),
        .o_cycle_count (o_cycle_count),
        .o_state       (o_state)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_chk = 0;
    int n_pass = 0;
    int lo_cnt = 0;
    int done_cnt = 0;

    // Reference model: 0 STOPPED, 1 RUN, 2 STEP, 3 HALTED; response is a byte queue.
    int          m_state, m_rem, m_pst;
    logic [7:0]  m_hi;
    logic [31:0] m_count;
    logic [7:0]  m_rsp[$];
    bit          m_acc, m_done;

    task automatic model_reset();
        m_state = 0; m_rem = 0; m_pst = 0; m_hi = 8'h00;
        m_count = 32'd0; m_rsp.delete(); m_acc = 0; m_done = 0;
    endtask

    function automatic bit m_stall();
        return !(m_state == 1 || m_state == 2);
    endfunction

    task automatic model_step();
        bit running, run, stop, stepc, cnt;
        int n;
        running = !m_stall();
        run = 0; stop = 0; stepc = 0; cnt = 0; n = 0;
        m_acc  = bus.cmd_valid && (m_rsp.size() == 0);
        m_done = 0;
        if (m_rsp.size() > 0 && bus.rsp_ready) void'(m_rsp.pop_front());
        if (m_acc) begin
            if (m_pst == 0) begin
                if (bus.cmd == 8'h52) run = 1;
                else if (bus.cmd == 8'h53) stop = 1;
                else if (bus.cmd == 8'h43) cnt = 1;
                else if (bus.cmd == 8'h4E) m_pst = 1;
            end else if (m_pst == 1) begin
                m_hi = bus.cmd; m_pst = 2;
            end else begin
                n = int'(m_hi) * 256 + int'(bus.cmd); stepc = 1; m_pst = 0;
            end
        end
        if (running) m_count = m_count + 32'd1;
        if (cnt) for (int i = 3; i >= 0; i--) m_rsp.push_back(m_count[i*8 +: 8]);
        if (running && i_halt) m_state = 3;
        else if (m_state == 0) begin
            if (run) m_state = 1;
            else if (stepc) begin
                if (n > 0) begin m_state = 2; m_rem = n; end
                else m_done = 1;
            end
        end else if (m_state == 2) begin
            if (stop) m_state = 0;
            else begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_state = 0; m_done = 1; end
            end
        end else if (stop) m_state = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (o_stall === 1'b0) lo_cnt++;
        if (o_step_done === 1'b1) done_cnt++;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = m_acc;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            $display("FAIL send_byte: byte %02h not accepted within 40 cycles", b);
        end
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_chk++; if (o_state !== 2'd0) $display("FAIL reset state: got %0d want 0", o_state); else n_pass++;
        n_chk++; if (o_stall !== 1'b1) $display("FAIL reset stall: got %b want 1", o_stall); else n_pass++;
        n_chk++; if (o_cycle_count !== 32'd0) $display("FAIL reset count: got %0d want 0", o_cycle_count); else n_pass++;
        n_chk++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
        n_chk++; if (bus.rsp_data !== 8'h00) $display("FAIL reset rsp_data: got %02h want 00", bus.rsp_data); else n_pass++;
        n_chk++; if (o_step_done !== 1'b0) $display("FAIL reset step_done: got %b want 0", o_step_done); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_run_stop();
        do_reset();
        lo_cnt = 0;
        repeat (4) tick();
        send_byte(CMD_RUN);
        repeat (9) tick();
        send_byte(CMD_STOP);
        repeat (3) tick();
        n_chk++; if (lo_cnt != 10) $display("FAIL run_stop unstalled cycles: got %0d want 10", lo_cnt); else n_pass++;
        n_chk++; if (o_cycle_count !== 32'd10) $display("FAIL run_stop count: got %0d want 10", o_cycle_count); else n_pass++;
        n_chk++; if (o_state !== 2'd0) $display("FAIL run_stop state: got %0d want 0", o_state); else n_pass++;
    endtask

    task automatic test_step();
        logic stall_at_done = 1'b0;
        do_reset();
        done_cnt = 0;
        send_byte(CMD_STEP); send_byte(8'h00); send_byte(8'h03);
        n_chk++; if (o_state !== 2'd2) $display("FAIL step state: got %0d want 2", o_state); else n_pass++;
        repeat (6) begin
            tick();
            if (o_step_done === 1'b1) stall_at_done = o_stall;
        end
        n_chk++; if (done_cnt != 1) $display("FAIL step done pulses: got %0d want 1", done_cnt); else n_pass++;
        n_chk++; if (stall_at_done !== 1'b1) $display("FAIL step stall at done: got %b want 1", stall_at_done); else n_pass++;
        n_chk++; if (o_cycle_count !== 32'd3) $display("FAIL step count: got %0d want 3", o_cycle_count); else n_pass++;
        done_cnt = 0;
        send_byte(CMD_STEP); send_byte(8'h00); send_byte(8'h00);
        repeat (3) tick();
        n_chk++; if (done_cnt != 1) $display("FAIL step0 done pulses: got %0d want 1", done_cnt); else n_pass++;
        n_chk++; if (o_cycle_count !== 32'd3) $display("FAIL step0 count: got %0d want 3", o_cycle_count); else n_pass++;
        n_chk++; if (o_state !== 2'd0) $display("FAIL step0 state: got %0d want 0", o_state); else n_pass++;
    endtask

    task automatic test_halt();
        int guard = 0;
        do_reset();
        send_byte(CMD_RUN);
        while (o_cycle_count !== 32'd7 && guard < 40) begin tick(); guard++; end
        n_chk++; if (o_cycle_count !== 32'd7) $display("FAIL halt reach count: got %0d want 7", o_cycle_count); else n_pass++;
        i_halt = 1'b1;
        tick();
        i_halt = 1'b0;
        n_chk++; if (o_state !== 2'd3) $display("FAIL halt state: got %0d want 3", o_state); else n_pass++;
        n_chk++; if (o_stall !== 1'b1) $display("FAIL halt stall: got %b want 1", o_stall); else n_pass++;
        tick();
        n_chk++; if (o_cycle_count !== 32'd8) $display("FAIL halt count: got %0d want 8", o_cycle_count); else n_pass++;
        send_byte(CMD_RUN);
        tick();
        n_chk++; if (o_state !== 2'd3) $display("FAIL halt ignores run: got %0d want 3", o_state); else n_pass++;
        send_byte(CMD_STOP);
        n_chk++; if (o_state !== 2'd0) $display("FAIL halt stop: got %0d want 0", o_state); else n_pass++;
    endtask

    task automatic test_count_rsp();
        int guard = 0;
        int got = 0;
        logic [7:0] got_b [4];
        logic [7:0] exp_b [4];
        logic ready_before_last = 1'b1;
        exp_b[0] = 8'h00; exp_b[1] = 8'h00; exp_b[2] = 8'h12; exp_b[3] = 8'h34;
        do_reset();
        send_byte(CMD_RUN);
        while (o_cycle_count !== 32'h1233 && guard < 6000) begin tick(); guard++; end
        send_byte(CMD_STOP);
        n_chk++; if (o_cycle_count !== 32'h1234) $display("FAIL count_rsp count: got %h want 00001234", o_cycle_count); else n_pass++;
        bus.rsp_ready = 1'b0;
        send_byte(CMD_COUNT);
        n_chk++; if (bus.cmd_ready !== 1'b0) $display("FAIL count_rsp busy ready: got %b want 0", bus.cmd_ready); else n_pass++;
        tick(); tick();
        n_chk++; if (bus.rsp_valid !== 1'b1) $display("FAIL count_rsp held valid: got %b want 1", bus.rsp_valid); else n_pass++;
        n_chk++; if (bus.rsp_data !== 8'h00) $display("FAIL count_rsp held data: got %02h want 00", bus.rsp_data); else n_pass++;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10 && got < 4; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                got_b[got] = bus.rsp_data;
                if (got == 3) ready_before_last = bus.cmd_ready;
                got++;
            end
            tick();
        end
        n_chk++; if (got != 4) $display("FAIL count_rsp byte count: got %0d want 4", got); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (got_b[i] !== exp_b[i]) $display("FAIL count_rsp byte%0d: got %02h want %02h", i, got_b[i], exp_b[i]);
            else n_pass++;
        end
        n_chk++; if (ready_before_last !== 1'b0) $display("FAIL count_rsp ready before last: got %b want 0", ready_before_last); else n_pass++;
        n_chk++; if (bus.cmd_ready !== 1'b1) $display("FAIL count_rsp ready after: got %b want 1", bus.cmd_ready); else n_pass++;
        n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL count_rsp valid after: got %b want 0", bus.rsp_valid); else n_pass++;
    endtask

    task automatic test_step_abort();
        do_reset();
        done_cnt = 0;
        lo_cnt = 0;
        send_byte(CMD_STEP); send_byte(8'h01); send_byte(8'h00);
        repeat (49) tick();
        send_byte(CMD_STOP);
        repeat (3) tick();
        n_chk++; if (o_cycle_count !== 32'd50) $display("FAIL abort count: got %0d want 50", o_cycle_count); else n_pass++;
        n_chk++; if (lo_cnt != 50) $display("FAIL abort unstalled cycles: got %0d want 50", lo_cnt); else n_pass++;
        n_chk++; if (done_cnt != 0) $display("FAIL abort done pulses: got %0d want 0", done_cnt); else n_pass++;
        n_chk++; if (o_stall !== 1'b1) $display("FAIL abort stall: got %b want 1", o_stall); else n_pass++;
        send_byte(CMD_STEP); send_byte(8'h52); send_byte(8'h53);
        n_chk++; if (o_state !== 2'd2) $display("FAIL operand literal state: got %0d want 2", o_state); else n_pass++;
        repeat (10) tick();
        n_chk++; if (o_state !== 2'd2) $display("FAIL operand literal still stepping: got %0d want 2", o_state); else n_pass++;
        send_byte(CMD_STOP);
        n_chk++; if (o_cycle_count !== 32'd61) $display("FAIL operand literal count: got %0d want 61", o_cycle_count); else n_pass++;
        n_chk++; if (o_state !== 2'd0) $display("FAIL operand literal stop: got %0d want 0", o_state); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        do_reset();
        send_byte(CMD_STEP); send_byte(8'h00); send_byte(8'h40);
        repeat (5) tick();
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        n_chk++; if (o_state !== 2'd0) $display("FAIL areset step state: got %0d want 0", o_state); else n_pass++;
        n_chk++; if (o_stall !== 1'b1) $display("FAIL areset step stall: got %b want 1", o_stall); else n_pass++;
        n_chk++; if (o_cycle_count !== 32'd0) $display("FAIL areset step count: got %0d want 0", o_cycle_count); else n_pass++;
        #2;
        rst = 1'b1;
        send_byte(CMD_RUN);
        repeat (3) tick();
        bus.rsp_ready = 1'b0;
        send_byte(CMD_COUNT);
        tick();
        n_chk++; if (bus.rsp_valid !== 1'b1) $display("FAIL areset rsp pending: got %b want 1", bus.rsp_valid); else n_pass++;
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL areset rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
        n_chk++; if (bus.rsp_data !== 8'h00) $display("FAIL areset rsp_data: got %02h want 00", bus.rsp_data); else n_pass++;
        n_chk++; if (bus.cmd_ready !== 1'b1) $display("FAIL areset cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        n_chk++; if (o_cycle_count !== 32'd0) $display("FAIL areset rsp count: got %0d want 0", o_cycle_count); else n_pass++;
        #2;
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (8) begin
            tick();
            if (bus.rsp_valid === 1'b1) seen = 1;
        end
        n_chk++; if (seen) $display("FAIL areset stray rsp: got valid after reset want none"); else n_pass++;
        n_chk++; if (o_cycle_count !== 32'd0) $display("FAIL areset idle count: got %0d want 0", o_cycle_count); else n_pass++;
    endtask

    task automatic test_random();
        bit hold;
        int bad = 0;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            hold = bus.cmd_valid && !m_acc;
            if (!hold) begin
                bus.cmd_valid = ($urandom_range(0, 3) == 0);
                if (m_pst == 1) bus.cmd = 8'h00;
                else if (m_pst == 2) bus.cmd = 8'($urandom_range(0, 6));
                else begin
                    case ($urandom_range(0, 7))
                        0, 1:    bus.cmd = CMD_RUN;
                        2:       bus.cmd = CMD_STOP;
                        3, 4:    bus.cmd = CMD_STEP;
                        5:       bus.cmd = CMD_COUNT;
                        default: bus.cmd = 8'($urandom);
                    endcase
                end
            end
            i_halt = ($urandom_range(0, 29) == 0);
            bus.rsp_ready = 1'($urandom_range(0, 1));
            tick();
            n_chk++; if (o_state !== 2'(m_state)) begin bad++; $display("FAIL rand state @%0d: got %0d want %0d", cyc, o_state, m_state); end else n_pass++;
            n_chk++; if (o_stall !== m_stall()) begin bad++; $display("FAIL rand stall @%0d: got %b want %b", cyc, o_stall, m_stall()); end else n_pass++;
            n_chk++; if (o_cycle_count !== m_count) begin bad++; $display("FAIL rand count @%0d: got %0d want %0d", cyc, o_cycle_count, m_count); end else n_pass++;
            n_chk++; if (o_step_done !== m_done) begin bad++; $display("FAIL rand step_done @%0d: got %b want %b", cyc, o_step_done, m_done); end else n_pass++;
            n_chk++; if (bus.rsp_valid !== (m_rsp.size() != 0)) begin bad++; $display("FAIL rand rsp_valid @%0d: got %b want %b", cyc, bus.rsp_valid, m_rsp.size() != 0); end else n_pass++;
            n_chk++; if (bus.cmd_ready !== (m_rsp.size() == 0)) begin bad++; $display("FAIL rand cmd_ready @%0d: got %b want %b", cyc, bus.cmd_ready, m_rsp.size() == 0); end else n_pass++;
            if (m_rsp.size() != 0) begin
                n_chk++; if (bus.rsp_data !== m_rsp[0]) begin bad++; $display("FAIL rand rsp_data @%0d: got %02h want %02h", cyc, bus.rsp_data, m_rsp[0]); end else n_pass++;
            end
            if (bad > 0) model_reset();
            if (bad > 0) begin
                // Stop the random phase after the first divergence; the model no longer tracks the DUT.
                cyc = 800;
            end
        end
        bus.cmd_valid = 1'b0;
        i_halt = 1'b0;
        bus.rsp_ready = 1'b1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd = 8'h00;
        bus.rsp_ready = 1'b1;
        model_reset();
        test_reset();
        test_run_stop();
        test_step();
        test_halt();
        test_count_rsp();
        test_step_abort();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
